// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit between EX/MEM and MEM/WB.
// Drives a req/gnt/rvalid data bus, extends load data, and stalls EX/MEM
// while an access is outstanding.
// Optional feature: define LSU_TIMEOUT_EN to abort a hung access after
// TIMEOUT_CYC stalled cycles with a one-cycle bus_err_o pulse.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_wren_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [2:0]  fun_i,
    input  logic        rd_wren_i,
    input  logic [31:0] alu_da_i,
    input  logic [31:0] rs2_da_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic [31:0] ld_da_o,
    output logic        rd_wren_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        WAIT_R = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        is_load, is_store, is_op;
    logic        sz_byte, sz_half, sz_word;
    logic        mis;
    logic        req_raw, stall_raw, done_ld;
    logic        tmo;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_ext;

    // Decode access type, size and alignment from the EX/MEM bundle
    always_comb begin
        is_load  = (wb_sel_i == 2'b01) & ~mem_wren_i;
        is_store = mem_wren_i;
        is_op    = is_load | is_store;
        sz_byte  = (fun_i == 3'b000) | (is_load & (fun_i == 3'b100));
        sz_half  = (fun_i == 3'b001) | (is_load & (fun_i == 3'b101));
        sz_word  = ~sz_byte & ~sz_half;
        mis      = is_op & ((sz_half & alu_da_i[0]) |
                            (sz_word & (alu_da_i[1:0] != 2'b00)));
    end

    // Store lane placement; loads always enable the full word
    always_comb begin
        dbus_be_o    = '1;
        dbus_wdata_o = rs2_da_i;
        if (is_store) begin
            if (sz_byte) begin
                dbus_be_o    = 4'b0001 << alu_da_i[1:0];
                dbus_wdata_o = {4{rs2_da_i[7:0]}};
            end else if (sz_half) begin
                dbus_be_o    = alu_da_i[1] ? 4'b1100 : 4'b0011;
                dbus_wdata_o = {2{rs2_da_i[15:0]}};
            end
        end
    end

    // Load lane select and sign/zero extension
    always_comb begin
        case (alu_da_i[1:0])
            2'd0:    lane_b = dbus_rdata_i[7:0];
            2'd1:    lane_b = dbus_rdata_i[15:8];
            2'd2:    lane_b = dbus_rdata_i[23:16];
            default: lane_b = dbus_rdata_i[31:24];
        endcase
        lane_h = alu_da_i[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        if (sz_byte)
            ld_ext = fun_i[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
        else if (sz_half)
            ld_ext = fun_i[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
        else
            ld_ext = dbus_rdata_i;
    end

    // Handshake: request until gnt, then wait for rvalid on loads
    always_comb begin
        state_d   = state_q;
        req_raw   = 1'b0;
        stall_raw = 1'b0;
        done_ld   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_op && !mis) begin
                    req_raw = 1'b1;
                    if (dbus_gnt_i) begin
                        if (is_load) begin
                            stall_raw = 1'b1;
                            state_d   = WAIT_R;
                        end
                    end else begin
                        stall_raw = 1'b1;
                    end
                end
            end
            default: begin
                if (dbus_rvalid_i) begin
                    done_ld = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_clr;

    // Stall watchdog: counts stalled cycles since the last bus event
    always_comb begin
        tmo     = stall_raw & (cnt_q == CW'(TIMEOUT_CYC - 1));
        cnt_clr = tmo | (state_d != state_q) | (req_raw & dbus_gnt_i) |
                  ((state_q == WAIT_R) & dbus_rvalid_i);
        cnt_d   = (cnt_clr || !stall_raw) ? '0 : cnt_q + 1'b1;
    end

    // Watchdog counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign bus_err_o = tmo;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign tmo                = 1'b0;
    assign bus_err_o          = 1'b0;
`endif

    // State register; an abort always lands back in IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= tmo ? IDLE : state_d;
    end

    assign dbus_req_o  = req_raw & ~tmo;
    assign dbus_we_o   = is_store;
    assign dbus_addr_o = {alu_da_i[31:2], 2'b00};
    assign stall_o     = stall_raw & ~tmo;
    assign misalign_o  = mis;
    assign rd_wren_o   = rd_wren_i & ~mis & ~tmo;
    assign ld_da_o     = (done_ld && !tmo) ? ld_ext : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized scoreboard bench for mem_stage_lsu.
module tb_mem_stage_lsu;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TO_CYC = 4;
`else
    localparam int unsigned TO_CYC = 255;
`endif

    logic        clk, rst_ni;
    logic        mem_wren, rd_wren, gnt, rvalid;
    logic [1:0]  wb_sel;
    logic [2:0]  fun;
    logic [31:0] alu_da, rs2_da, rdata;
    logic        req, we, ld_wren_o, stall, misal, berr;
    logic [31:0] addr_o, wdata_o, ld_da;
    logic [3:0]  be_o;

    mem_stage_lsu #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .mem_wren_i(mem_wren), .wb_sel_i(wb_sel), .fun_i(fun),
        .rd_wren_i(rd_wren), .alu_da_i(alu_da), .rs2_da_i(rs2_da),
        .dbus_req_o(req), .dbus_we_o(we), .dbus_addr_o(addr_o),
        .dbus_be_o(be_o), .dbus_wdata_o(wdata_o),
        .dbus_gnt_i(gnt), .dbus_rvalid_i(rvalid), .dbus_rdata_i(rdata),
        .ld_da_o(ld_da), .rd_wren_o(ld_wren_o), .stall_o(stall),
        .misalign_o(misal), .bus_err_o(berr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic stall; logic req; logic mis; logic rdw; } cyc_t;
    typedef struct { logic st; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic [31:0] ld; } txn_t;

    cyc_t cyc_q[$];
    txn_t txn_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic ld_pend = 1'b0;
    cyc_t mc;
    txn_t mt;

    // next instruction presented on the first cycle of an access
    logic        n_wren, n_rdw;
    logic [1:0]  n_wbsel;
    logic [2:0]  n_fun;
    logic [31:0] n_addr, n_rs2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock cycle of stimulus plus its expected per-cycle outputs
    task automatic step(input bit ld_ins, input logic g, input logic rv, input logic [31:0] rd,
                        input logic es, input logic er, input logic em, input logic ew);
        cyc_t c;
        @(posedge clk); #1;
        if (ld_ins) begin
            mem_wren = n_wren; wb_sel = n_wbsel; fun = n_fun;
            rd_wren = n_rdw; alu_da = n_addr; rs2_da = n_rs2;
        end
        gnt = g; rvalid = rv; rdata = rd;
        c.stall = es; c.req = er; c.mis = em; c.rdw = ew;
        cyc_q.push_back(c);
        mon_en = 1'b1;
    endtask

    // kind: 0 = non-memory op, 1 = load, 2 = store
    task automatic do_access(input int kind, input logic [2:0] fun_v, input logic [31:0] addr,
                             input logic [31:0] rs2, input logic [31:0] rd_v,
                             input int gd, input int rdl, input logic rdw);
        int          sz, off;
        bit          uns, mis;
        logic [31:0] v, bm;
        logic [1:0]  ws;
        txn_t        t;
        sz = 4; uns = 0;
        if (kind == 1) begin
            case (fun_v)
                3'd0: sz = 1;
                3'd1: sz = 2;
                3'd4: begin sz = 1; uns = 1; end
                3'd5: begin sz = 2; uns = 1; end
                default: sz = 4;
            endcase
        end else if (kind == 2) begin
            case (fun_v)
                3'd0: sz = 1;
                3'd1: sz = 2;
                default: sz = 4;
            endcase
        end
        off = int'(addr % 4);
        mis = (kind != 0) && (off % sz != 0);

        ws = 2'($urandom_range(0, 2));
        if (ws == 2'b01) ws = 2'b11;
        n_wren = (kind == 2); n_fun = fun_v; n_addr = addr; n_rs2 = rs2; n_rdw = rdw;
        n_wbsel = (kind == 1) ? 2'b01 : (kind == 2) ? 2'($urandom_range(0, 3)) : ws;

        if (kind == 0 || mis) begin
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 0, 0, mis, rdw & ~mis);
        end else begin
            t.st = (kind == 2);
            t.addr = addr - 32'(off);
            bm = ((32'd1 << sz) - 1) << off;
            t.be = (kind == 2) ? bm[3:0] : 4'hF;
            t.wdata = (sz == 1) ? 32'(rs2 % 256) * 32'h0101_0101 :
                      (sz == 2) ? 32'(rs2 % 65536) * 32'h0001_0001 : rs2;
            v = rd_v >> (8 * off);
            if (sz == 1) begin
                v = v % 256;
                if (!uns && v >= 128) v = v - 256;
            end else if (sz == 2) begin
                v = v % 65536;
                if (!uns && v >= 32768) v = v - 65536;
            end
            t.ld = v;
            txn_q.push_back(t);
            for (int i = 0; i < gd; i++)
                step(i == 0, 0, 1'($urandom_range(0, 1)), $urandom, 1, 1, 0, rdw);
            step(gd == 0, 1, 1'($urandom_range(0, 1)), $urandom, kind == 1, 1, 0, rdw);
            if (kind == 1) begin
                for (int i = 0; i < rdl; i++)
                    step(0, 1'($urandom_range(0, 1)), 0, $urandom, 1, 0, 0, rdw);
                step(0, 0, 1, rd_v, 0, 0, 0, rdw);
            end
        end
    endtask

    // monitor: per-cycle checks plus bus-transaction scoreboard
    always @(negedge clk) begin
        if (!rst_ni) begin
            ld_pend <= 1'b0;
        end else if (mon_en) begin
            if (cyc_q.size() == 0) begin
                chk("cyc_q_underflow", 32'd1, 32'd0);
            end else begin
                mc = cyc_q.pop_front();
                chk("stall", stall, mc.stall);
                chk("req", req, mc.req);
                chk("misalign", misal, mc.mis);
                chk("rd_wren", ld_wren_o, mc.rdw);
                chk("bus_err", berr, 0);
            end
            if (rvalid && ld_pend) begin
                if (txn_q.size() == 0) chk("ld_no_txn", 32'd1, 32'd0);
                else begin
                    mt = txn_q.pop_front();
                    chk("ld_da", ld_da, mt.ld);
                end
                ld_pend <= 1'b0;
            end else begin
                chk("ld_da_idle", ld_da, 0);
            end
            if (req && gnt) begin
                if (txn_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
                else begin
                    mt = txn_q[0];
                    chk("addr", addr_o, mt.addr);
                    chk("we", we, mt.st);
                    chk("be", be_o, mt.be);
                    if (mt.st) begin
                        chk("wdata", wdata_o, mt.wdata);
                        void'(txn_q.pop_front());
                    end else begin
                        ld_pend <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic zero_inputs();
        mem_wren = 0; wb_sel = 0; fun = 0; rd_wren = 0;
        alu_da = 0; rs2_da = 0; gnt = 0; rvalid = 0; rdata = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        zero_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ld", ld_da, 0);
        chk("rst_berr", berr, 0);
        chk("rst_misalign", misal, 0);
        #1 rst_ni = 1'b1;

        // directed cases
        do_access(2, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
        do_access(1, 3'b000, 32'h0000_2003, 0, 32'h80FF_1234, 2, 0, 1'b1);
        do_access(1, 3'b101, 32'h0000_2002, 0, 32'h8001_0000, 1, 1, 1'b1);
        do_access(1, 3'b001, 32'h0000_2002, 0, 32'h8001_0000, 0, 0, 1'b1);
        do_access(2, 3'b001, 32'h0000_3001, 32'h1234_5678, 0, 0, 0, 1'b1);
        do_access(1, 3'b100, 32'h0000_2001, 0, 32'h0000_F000, 0, 2, 1'b1);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int k;
            k = int'($urandom_range(0, 4));
            do_access((k == 0) ? 0 : (k <= 2) ? 1 : 2, 3'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        do_access(0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
        @(negedge clk); #1;
        mon_en = 1'b0;

        // asynchronous reset while waiting for read data
        @(posedge clk); #1;
        zero_inputs();
        wb_sel = 2'b01; fun = 3'b010; alu_da = 32'h40; rd_wren = 1; gnt = 1;
        @(negedge clk);
        chk("mrst_req", req, 1);
        @(posedge clk); #1;
        gnt = 0;
        @(negedge clk);
        chk("mrst_wait_stall", stall, 1);
        chk("mrst_wait_req", req, 0);
        #2;
        rst_ni = 1'b0;
        zero_inputs();
        #1;
        chk("mrst_stall", stall, 0);
        chk("mrst_req0", req, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1; rvalid = 1; rdata = 32'h1234_5678;
        @(negedge clk);
        chk("mrst_stale_ld", ld_da, 0);
        chk("mrst_stale_stall", stall, 0);
        @(posedge clk); #1;
        rvalid = 0; wb_sel = 2'b01; fun = 3'b010; alu_da = 32'h44;
        @(negedge clk);
        chk("mrst_idle_req", req, 1);
        chk("mrst_idle_stall", stall, 1);
        @(posedge clk); #1;
        gnt = 1;
        @(posedge clk); #1;
        gnt = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("mrst_ld", ld_da, 32'hCAFE_F00D);
        chk("mrst_done_stall", stall, 0);
        @(posedge clk); #1;
        zero_inputs();

`ifdef LSU_TIMEOUT_EN
        // load that is never granted
        @(posedge clk); #1;
        wb_sel = 2'b01; fun = 3'b010; alu_da = 32'h100; rd_wren = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_stall", stall, 1);
            chk("to_berr_low", berr, 0);
        end
        @(negedge clk);
        chk("to_stall_drop", stall, 0);
        chk("to_req_drop", req, 0);
        chk("to_berr", berr, 1);
        chk("to_rd_wren", ld_wren_o, 0);
        chk("to_ld", ld_da, 0);
        @(posedge clk); #1;
        zero_inputs();
        rvalid = 1; rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("to_late_ld", ld_da, 0);
        chk("to_berr_pulse", berr, 0);
        @(posedge clk); #1;
        rvalid = 0;
`endif

        chk("txn_q_empty", txn_q.size(), 0);
        chk("cyc_q_empty", cyc_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
